mux_scan_controller: RTL and testbench

//  Sequencer in front of four_to_one_mux. Drives the mux select through the

---
 rtl/mux_scan_pkg.sv | 23 ++
 rtl/next_channel_finder.sv | 24 ++
 rtl/mux_scan_controller.sv | 98 +++++++++
 tb/tb_mux_scan_controller.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan controller.
// Channel count, select width, FSM state type and the first-channel lookup.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Lowest set bit of the mask; returns 0 for an empty mask
  function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] ch;
    ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) ch = SEL_W'(i);
    end
    return ch;
  endfunction

endpackage

// File: rtl/next_channel_finder.sv
// Finds the next higher enabled channel above the current one.
// Flags 'last' when no higher enabled channel exists.
module next_channel_finder
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              last
);

  // Walking downward lets the lowest qualifying channel win
  always_comb begin
    nxt  = cur;
    last = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt  = SEL_W'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_controller.sv
// Steps a four-to-one mux select through the enabled channels, dwelling on each,
// and publishes a 4-bit snapshot with a one-cycle valid pulse per completed scan.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] sample,
  output logic              sample_valid,
  output logic              busy
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] snapshot;
  logic [SEL_W-1:0]  nxt;
  logic              last;

  next_channel_finder u_finder (
    .mask (mask_q),
    .cur  (sel),
    .nxt  (nxt),
    .last (last)
  );

  // The final channel's bit is merged straight in so the snapshot is complete on the end edge
  always_comb begin
    snapshot      = shadow;
    snapshot[sel] = mux_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      cnt          <= '0;
      mask_q       <= '0;
      shadow       <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (ch_mask != '0)) begin
            state  <= SCAN;
            busy   <= 1'b1;
            mask_q <= ch_mask;
            sel    <= first_ch(ch_mask);
            cnt    <= '0;
            shadow <= '0;
          end
        end
        SCAN: begin
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            shadow[sel] <= mux_out;
            if (!last) begin
              sel <= nxt;
            end else begin
              sample       <= snapshot;
              sample_valid <= 1'b1;
              // Restart reuses the accept actions, re-latching the live mask
              if (continuous && (ch_mask != '0)) begin
                mask_q <= ch_mask;
                sel    <= first_ch(ch_mask);
                shadow <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed self-checking bench for mux_scan_controller with DWELL=2,
// driving mux_out from a behavioural four-to-one mux on the controller's select.
module tb_mux_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       continuous;
  logic [3:0] ch_mask;
  logic [3:0] mux_in;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] sample;
  logic       sample_valid;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Stand-in for four_to_one_mux
  assign mux_out = mux_in[sel];

  mux_scan_controller #(.DWELL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .ch_mask      (ch_mask),
    .mux_out      (mux_out),
    .sel          (sel),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic cont, input logic [3:0] mask, input logic [3:0] in);
    start      = s;
    continuous = cont;
    ch_mask    = mask;
    mux_in     = in;
  endtask

  // Single-shot scan; exp_seq holds the expected sel per cycle, two bits each, cycle 0 in bits [1:0]
  task automatic runScan(input string tag, input logic [3:0] mask, input logic [3:0] in,
                         input int nsel, input logic [15:0] exp_seq, input logic [3:0] exp_sample,
                         input bit disturb);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, mask, in);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < nsel; i++) begin
      if (disturb && i == 3) begin
        start   = 1'b1;
        ch_mask = 4'b0001;
      end
      if (disturb && i == 4) start = 1'b0;
      checkOutput($sformatf("%s_sel%0d", tag, i), 32'(sel), 32'(exp_seq[2*i +: 2]));
      checkOutput($sformatf("%s_novalid%0d", tag, i), 32'(sample_valid), 32'd0);
      checkOutput($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkOutput({tag, "_valid"}, 32'(sample_valid), 32'd1);
    checkOutput({tag, "_sample"}, 32'(sample), 32'(exp_sample));
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 32'(sample_valid), 32'd0);
    checkOutput({tag, "_sample_hold"}, 32'(sample), 32'(exp_sample));
  endtask

  initial begin
    // Reset held for three cycles
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_sample", 32'(sample), 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Full scan of all four channels
    runScan("t2", 4'b1111, 4'b1010, 8, 16'hFA50, 4'b1010, 1'b0);

    // Sparse mask visits only channels 0 and 2
    runScan("t3", 4'b0101, 4'b1111, 4, 16'h00A0, 4'b0101, 1'b0);

    // start and mask disturbance mid-scan must not alter the scan
    runScan("t5", 4'b1111, 4'b1010, 8, 16'hFA50, 4'b1010, 1'b1);

    // Empty-mask start is ignored
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_busy%0d", i), 32'(busy), 32'd0);
      checkOutput($sformatf("t6_valid%0d", i), 32'(sample_valid), 32'd0);
    end
    start = 1'b0;

    // Continuous single-channel scan with a toggling input
    applyStimulus(1'b1, 1'b1, 4'b1000, 4'b0000);
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      mux_in[3] = (p % 2 == 0);
      checkOutput($sformatf("t4_sel%0d", p), 32'(sel), 32'd3);
      @(negedge clk);
      checkOutput($sformatf("t4_gap%0d", p), 32'(sample_valid), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("t4_valid%0d", p), 32'(sample_valid), 32'd1);
      checkOutput($sformatf("t4_sample%0d", p), 32'(sample), (p % 2 == 0) ? 32'h8 : 32'h0);
      checkOutput($sformatf("t4_busy%0d", p), 32'(busy), 32'd1);
    end

    // Mask dropped during continuous mode: one last pulse, then IDLE
    ch_mask   = 4'b0000;
    mux_in[3] = 1'b1;
    @(negedge clk);
    checkOutput("t6b_gap", 32'(sample_valid), 32'd0);
    @(negedge clk);
    checkOutput("t6b_valid", 32'(sample_valid), 32'd1);
    checkOutput("t6b_sample", 32'(sample), 32'h8);
    checkOutput("t6b_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t6b_idle_valid", 32'(sample_valid), 32'd0);
    checkOutput("t6b_idle_busy", 32'(busy), 32'd0);
    continuous = 1'b0;

    // Asynchronous reset in the middle of a scan
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1010);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t1_pre_sel", 32'(sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("t1_async_sel", 32'(sel), 32'd0);
    checkOutput("t1_async_sample", 32'(sample), 32'd0);
    checkOutput("t1_async_valid", 32'(sample_valid), 32'd0);
    checkOutput("t1_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t1_after_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
